// File: rtl/fetch_queue_unit.sv
// Decoupled instruction-fetch front end: issues word fetches to instruction memory,
// buffers fetched words with their PC in a small FIFO, and handles branch/jump redirects.
module fetch_queue_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc_plus4,
    output logic            inst_fault,
    output logic [XLEN-1:0] fetch_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            fault;
    } entry_t;

    state_t           state, state_nxt;
    logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt;
    logic             discard, discard_nxt;
    logic [PTR_W-1:0] rptr, wptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];
    entry_t           head;

    logic             pop_c;
    logic             push_c;
    logic             flush_c;
    logic             req_valid_c;
    logic             outstanding_c;
    entry_t           push_entry_c;

    assign pop_c = (count != '0) && inst_ready;

    // Next-state logic; a redirect overrides whatever the current state decided.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        discard_nxt   = discard;
        req_valid_c   = 1'b0;
        push_c        = 1'b0;
        flush_c       = 1'b0;
        outstanding_c = 1'b0;
        push_entry_c  = '0;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Reserve a slot at issue, counting the entry freed by a same-cycle pop.
                req_valid_c = (count < CNT_W'(DEPTH)) || pop_c;
                if (req_valid_c && imem_req_ready) begin
                    state_nxt     = ST_WAIT;
                    fetch_pc_nxt  = fetch_pc + XLEN'(4);
                    outstanding_c = 1'b1;
                end
            end
            ST_WAIT: begin
                outstanding_c = !imem_rsp_valid;
                if (imem_rsp_valid) begin
                    push_c       = !discard;
                    push_entry_c = '{data:     imem_rsp_data,
                                     pc:       fetch_pc - XLEN'(4),
                                     pc_plus4: fetch_pc,
                                     fault:    1'b0};
                    state_nxt    = ST_ISSUE;
                    discard_nxt  = 1'b0;
                end
            end
            ST_HALT: begin
                // A stale fetch may still be in flight from the redirect that halted us.
                outstanding_c = discard && !imem_rsp_valid;
                if (imem_rsp_valid) begin
                    discard_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A fetch still in flight after a redirect is waited out in WAIT and then dropped.
        if (redirect_valid && (state != ST_IDLE)) begin
            flush_c     = 1'b1;
            discard_nxt = outstanding_c;
            if (redirect_pc[1:0] == 2'b00) begin
                push_c       = 1'b0;
                fetch_pc_nxt = redirect_pc;
                state_nxt    = outstanding_c ? ST_WAIT : ST_ISSUE;
            end else begin
                push_c       = 1'b1;
                push_entry_c = '{data:     '0,
                                 pc:       redirect_pc,
                                 pc_plus4: redirect_pc + XLEN'(4),
                                 fault:    1'b1};
                state_nxt    = ST_HALT;
            end
        end
    end

    // FSM and fetch-side registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            discard  <= discard_nxt;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush_c) begin
            rptr  <= '0;
            wptr  <= push_c ? PTR_W'(1) : '0;
            count <= push_c ? CNT_W'(1) : '0;
        end else begin
            if (push_c) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_c) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Entry storage; a flush-time push always lands in slot 0.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[flush_c ? '0 : wptr] <= push_entry_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (pop_c) begin
            fetch_count <= fetch_count + XLEN'(1);
        end
    end

    assign head           = mem[rptr];
    assign inst_valid     = (count != '0);
    assign inst_data      = inst_valid ? head.data     : '0;
    assign inst_pc        = inst_valid ? head.pc       : '0;
    assign inst_pc_plus4  = inst_valid ? head.pc_plus4 : '0;
    assign inst_fault     = inst_valid ? head.fault    : 1'b0;
    assign imem_req_valid = req_valid_c;
    assign imem_req_addr  = fetch_pc;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a variable-latency memory model plus per-scenario tasks.
`timescale 1ns/1ps
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        inst_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_pc4_q[$];
    logic [31:0] pop_data_q[$];
    logic        pop_fault_q[$];

    int          rsp_lat  = 1;
    bit          mem_keep = 1'b0;
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;

    fetch_queue_unit #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .inst_pc_plus4(inst_pc_plus4),
        .inst_fault(inst_fault),
        .fetch_count(fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Memory model and pop/request logger, evaluated mid low phase so all inputs are settled.
    initial begin
        mem_pending    = 1'b0;
        mem_cnt        = 0;
        mem_addr       = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #5;
            if (rst_n !== 1'b1 && !mem_keep) mem_pending = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (mem_pending) begin
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;
                    mem_pending    = 1'b0;
                end else begin
                    mem_cnt = mem_cnt - 1;
                end
            end
            if (rst_n === 1'b1 && imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                req_q.push_back(imem_req_addr);
                mem_pending = 1'b1;
                mem_addr    = imem_req_addr;
                mem_cnt     = rsp_lat - 1;
            end
            if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
                pop_pc_q.push_back(inst_pc);
                pop_pc4_q.push_back(inst_pc_plus4);
                pop_data_q.push_back(inst_data);
                pop_fault_q.push_back(inst_fault);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        mem_keep       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int target, input string name);
        int k = 0;
        while (req_q.size() < target && k < 200) begin
            step();
            k++;
        end
        if (req_q.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s: request count %0d expected %0d", name, req_q.size(), target);
        end
    endtask

    task automatic pop_n(input int base, input int n, input string name, output bit ok);
        int k = 0;
        inst_ready = 1'b1;
        while ((pop_pc_q.size() - base) < n && k < 300) begin
            step();
            k++;
        end
        inst_ready = 1'b0;
        ok = ((pop_pc_q.size() - base) >= n);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: pops %0d expected %0d", name, pop_pc_q.size() - base, n);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        step();
        step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr: got %h expected 00000000", imem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_inst_data: got %h expected 0", inst_data); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
        checks++; if (inst_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_inst_pc4: got %h expected 0", inst_pc_plus4); end
        checks++; if (inst_fault !== 1'b0) begin errors++; $display("FAIL rst_inst_fault: got %b expected 0", inst_fault); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_fetch_count: got %0d expected 0", fetch_count); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 00000000", imem_req_addr); end
    endtask

    task automatic test_zero_wait();
        int base;
        bit ok;
        logic [31:0] exp_pc;
        reset_dut();
        rsp_lat = 1;
        base = pop_pc_q.size();
        pop_n(base, 4, "zw_pops", ok);
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                exp_pc = 32'(4 * i);
                checks++; if (pop_pc_q[base+i] !== exp_pc) begin errors++; $display("FAIL zw_pc%0d: got %h expected %h", i, pop_pc_q[base+i], exp_pc); end
                checks++; if (pop_pc4_q[base+i] !== exp_pc + 32'd4) begin errors++; $display("FAIL zw_pc4_%0d: got %h expected %h", i, pop_pc4_q[base+i], exp_pc + 32'd4); end
                checks++; if (pop_data_q[base+i] !== (exp_pc ^ 32'hA5A5_0000)) begin errors++; $display("FAIL zw_data%0d: got %h expected %h", i, pop_data_q[base+i], exp_pc ^ 32'hA5A5_0000); end
                checks++; if (pop_fault_q[base+i] !== 1'b0) begin errors++; $display("FAIL zw_fault%0d: got %b expected 0", i, pop_fault_q[base+i]); end
            end
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL zw_fetch_count: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_backpressure();
        int rbase;
        int base;
        bit ok;
        reset_dut();
        rsp_lat = 1;
        rbase = req_q.size();
        repeat (20) step();
        checks++; if (req_q.size() - rbase !== 4) begin errors++; $display("FAIL bp_requests: got %0d expected 4", req_q.size() - rbase); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_full: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", inst_pc); end
        base = pop_pc_q.size();
        pop_n(base, 6, "bp_pops", ok);
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (pop_pc_q[base+i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_pc%0d: got %h expected %h", i, pop_pc_q[base+i], 32'(4 * i)); end
            end
        end
    endtask

    task automatic test_redirect_wait();
        int rbase;
        int base;
        bit ok;
        reset_dut();
        rsp_lat = 3;
        rbase = req_q.size();
        wait_req(rbase + 1, "rw_first_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_queue_empty: got %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_no_second_req: got %b expected 0", imem_req_valid); end
        base = pop_pc_q.size();
        wait_req(rbase + 2, "rw_target_req");
        if (req_q.size() >= rbase + 2) begin
            checks++; if (req_q[rbase+1] !== 32'h100) begin errors++; $display("FAIL rw_req_addr: got %h expected 00000100", req_q[rbase+1]); end
        end
        pop_n(base, 1, "rw_pop", ok);
        if (ok) begin
            checks++; if (pop_pc_q[base] !== 32'h100) begin errors++; $display("FAIL rw_pop_pc: got %h expected 00000100", pop_pc_q[base]); end
            checks++; if (pop_data_q[base] !== 32'hA5A5_0100) begin errors++; $display("FAIL rw_pop_data: got %h expected a5a50100", pop_data_q[base]); end
            checks++; if (pop_pc4_q[base] !== 32'h104) begin errors++; $display("FAIL rw_pop_pc4: got %h expected 00000104", pop_pc4_q[base]); end
        end
    endtask

    task automatic test_fault();
        int rsnap;
        int base;
        bit ok;
        reset_dut();
        rsp_lat = 1;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ft_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_fault !== 1'b1) begin errors++; $display("FAIL ft_fault: got %b expected 1", inst_fault); end
        checks++; if (inst_pc !== 32'h102) begin errors++; $display("FAIL ft_pc: got %h expected 00000102", inst_pc); end
        checks++; if (inst_pc_plus4 !== 32'h106) begin errors++; $display("FAIL ft_pc4: got %h expected 00000106", inst_pc_plus4); end
        checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL ft_data: got %h expected 0", inst_data); end
        rsnap = req_q.size();
        repeat (10) step();
        checks++; if (req_q.size() !== rsnap) begin errors++; $display("FAIL ft_halt_reqs: got %0d expected %0d", req_q.size(), rsnap); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL ft_halt_valid: got %b expected 0", imem_req_valid); end
        checks++; if (inst_fault !== 1'b1) begin errors++; $display("FAIL ft_held: got %b expected 1", inst_fault); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        base = pop_pc_q.size();
        step();
        redirect_valid = 1'b0;
        wait_req(rsnap + 1, "ft_resume_req");
        if (req_q.size() >= rsnap + 1) begin
            checks++; if (req_q[rsnap] !== 32'h200) begin errors++; $display("FAIL ft_resume_addr: got %h expected 00000200", req_q[rsnap]); end
        end
        pop_n(base, 1, "ft_resume_pop", ok);
        if (ok) begin
            checks++; if (pop_pc_q[base] !== 32'h200) begin errors++; $display("FAIL ft_resume_pc: got %h expected 00000200", pop_pc_q[base]); end
            checks++; if (pop_fault_q[base] !== 1'b0) begin errors++; $display("FAIL ft_resume_fault: got %b expected 0", pop_fault_q[base]); end
        end
    endtask

    task automatic test_same_cycle();
        int rbase;
        int base;
        int k;
        bit hit;
        bit ok;
        reset_dut();
        rsp_lat = 2;
        rbase = 0;
        hit = 1'b0;
        k = 0;
        // Redirect in the very cycle a request is handshaken.
        while (!hit && k < 50) begin
            step();
            if (imem_req_valid === 1'b1) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h300;
                rbase = req_q.size();
                hit = 1'b1;
            end
            k++;
        end
        checks++; if (!hit) begin errors++; $display("FAIL sc_hs_setup: got no request expected one"); end
        base = pop_pc_q.size();
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sc_hs_empty: got %b expected 0", inst_valid); end
        wait_req(rbase + 2, "sc_hs_reqs");
        if (req_q.size() >= rbase + 2) begin
            checks++; if (req_q[rbase] !== 32'h0) begin errors++; $display("FAIL sc_hs_stale_addr: got %h expected 0", req_q[rbase]); end
            checks++; if (req_q[rbase+1] !== 32'h300) begin errors++; $display("FAIL sc_hs_target_addr: got %h expected 00000300", req_q[rbase+1]); end
        end
        pop_n(base, 1, "sc_hs_pop", ok);
        if (ok) begin
            checks++; if (pop_pc_q[base] !== 32'h300) begin errors++; $display("FAIL sc_hs_pop_pc: got %h expected 00000300", pop_pc_q[base]); end
            checks++; if (pop_data_q[base] !== 32'hA5A5_0300) begin errors++; $display("FAIL sc_hs_pop_data: got %h expected a5a50300", pop_data_q[base]); end
        end
        // Redirect in the very cycle a response is delivered.
        inst_ready = 1'b1;
        hit = 1'b0;
        k = 0;
        while (!hit && k < 50) begin
            step();
            #6;
            if (imem_rsp_valid === 1'b1) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h400;
                base  = pop_pc_q.size();
                rbase = req_q.size();
                hit = 1'b1;
            end
            k++;
        end
        checks++; if (!hit) begin errors++; $display("FAIL sc_rsp_setup: got no response expected one"); end
        inst_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sc_rsp_empty: got %b expected 0", inst_valid); end
        wait_req(rbase + 1, "sc_rsp_req");
        if (req_q.size() >= rbase + 1) begin
            checks++; if (req_q[rbase] !== 32'h400) begin errors++; $display("FAIL sc_rsp_target_addr: got %h expected 00000400", req_q[rbase]); end
        end
        pop_n(base, 1, "sc_rsp_pop", ok);
        if (ok) begin
            checks++; if (pop_pc_q[base] !== 32'h400) begin errors++; $display("FAIL sc_rsp_pop_pc: got %h expected 00000400", pop_pc_q[base]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int rb;
        int rb2;
        int base;
        bit ok;
        reset_dut();
        rsp_lat = 1;
        base = pop_pc_q.size();
        pop_n(base, 2, "rm_pre_pops", ok);
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL rm_pre_count: got %0d expected 2", fetch_count); end
        rsp_lat = 3;
        rb = req_q.size();
        wait_req(rb + 1, "rm_wait_req");
        mem_keep = 1'b1;
        rst_n    = 1'b0;
        step();
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rm_count_reset: got %0d expected 0", fetch_count); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rm_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rm_req_addr: got %h expected 0", imem_req_addr); end
        rb2 = req_q.size();
        base = pop_pc_q.size();
        rst_n = 1'b1;
        wait_req(rb2 + 1, "rm_first_req");
        if (req_q.size() >= rb2 + 1) begin
            checks++; if (req_q[rb2] !== 32'h0) begin errors++; $display("FAIL rm_first_addr: got %h expected 0", req_q[rb2]); end
        end
        pop_n(base, 2, "rm_pops", ok);
        if (ok) begin
            checks++; if (pop_pc_q[base] !== 32'h0) begin errors++; $display("FAIL rm_pop0_pc: got %h expected 0", pop_pc_q[base]); end
            checks++; if (pop_pc_q[base+1] !== 32'h4) begin errors++; $display("FAIL rm_pop1_pc: got %h expected 00000004", pop_pc_q[base+1]); end
        end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL rm_post_count: got %0d expected 2", fetch_count); end
        mem_keep = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_fault();
        test_same_cycle();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
